// File: rtl/cdb_arbiter_if.sv
// Bus between the execution units, the CDB arbiter and the CDB consumers.
// The arbiter takes the slave side; the execution-unit side is the master.
interface cdb_arbiter_if;
  logic        alu_valid;
  logic [3:0]  alu_tag;
  logic [31:0] alu_val;
  logic [31:0] alu_addr;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_val;
  logic [31:0] lsb_addr;
  logic        alu_stall;
  logic        lsb_stall;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [31:0] cdb_addr;
  logic        overflow_err;

  modport master (
    output alu_valid, alu_tag, alu_val, alu_addr,
    output lsb_valid, lsb_tag, lsb_val, lsb_addr,
    input  alu_stall, lsb_stall, cdb_active, cdb_tag, cdb_val, cdb_addr, overflow_err
  );

  modport slave (
    input  alu_valid, alu_tag, alu_val, alu_addr,
    input  lsb_valid, lsb_tag, lsb_val, lsb_addr,
    output alu_stall, lsb_stall, cdb_active, cdb_tag, cdb_val, cdb_addr, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per result source (ALU RS, LSB) and a
// round-robin pick of one queue head per cycle onto a registered CDB broadcast.
module cdb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [3:0]  NONE_TAG = 4'd0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam int unsigned   CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
    logic [31:0] addr;
  } result_t;

  // Index 0 is the ALU queue, index 1 the LSB queue.
  result_t       mem_q   [2][DEPTH];
  logic [PW-1:0] wptr_q  [2];
  logic [PW-1:0] rptr_q  [2];
  logic [CW-1:0] count_q [2];
  src_e          last_grant_q;
  logic          cdb_active_q;
  result_t       cdb_q;
  logic          overflow_q;

  result_t       in_res  [2];
  logic [CW-1:0] count_d [2];
  logic [1:0]    push_req;
  logic [1:0]    push_ok;
  logic [1:0]    drop;
  logic [1:0]    pop;
  logic [1:0]    nonempty;
  logic          grant_valid;
  src_e          grant_src;
  result_t       head;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    in_res[0]   = {bus.alu_tag, bus.alu_val, bus.alu_addr};
    in_res[1]   = {bus.lsb_tag, bus.lsb_val, bus.lsb_addr};
    push_req[0] = bus.alu_valid && (bus.alu_tag != NONE_TAG);
    push_req[1] = bus.lsb_valid && (bus.lsb_tag != NONE_TAG);
    nonempty[0] = (count_q[0] != '0);
    nonempty[1] = (count_q[1] != '0);

    // On contention the source that did not win last time goes first.
    grant_valid = |nonempty;
    grant_src   = SRC_ALU;
    if (&nonempty)
      grant_src = (last_grant_q == SRC_LSB) ? SRC_ALU : SRC_LSB;
    else if (nonempty[1])
      grant_src = SRC_LSB;

    pop  = grant_valid ? ((grant_src == SRC_LSB) ? 2'b10 : 2'b01) : 2'b00;
    head = (grant_src == SRC_LSB) ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];

    for (int s = 0; s < 2; s++) begin
      // A full queue still accepts a push when its head leaves in the same cycle.
      push_ok[s] = push_req[s] && !flush && ((count_q[s] != FULL_CNT) || pop[s]);
      drop[s]    = push_req[s] && !flush && (count_q[s] == FULL_CNT) && !pop[s];
      count_d[s] = count_q[s];
      if (push_ok[s] && !pop[s])
        count_d[s] = count_q[s] + CW'(1);
      else if (!push_ok[s] && pop[s])
        count_d[s] = count_q[s] - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s]  <= '0;
        rptr_q[s]  <= '0;
        count_q[s] <= '0;
      end
      last_grant_q <= SRC_LSB;
      cdb_active_q <= 1'b0;
      cdb_q        <= '0;
      overflow_q   <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int s = 0; s < 2; s++) begin
          wptr_q[s]  <= '0;
          rptr_q[s]  <= '0;
          count_q[s] <= '0;
        end
        last_grant_q <= SRC_LSB;
        cdb_active_q <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (push_ok[s]) wptr_q[s] <= wptr_q[s] + PW'(1);
          if (pop[s])     rptr_q[s] <= rptr_q[s] + PW'(1);
          count_q[s] <= count_d[s];
        end
        cdb_active_q <= grant_valid;
        if (grant_valid) begin
          cdb_q        <= head;
          last_grant_q <= grant_src;
        end
        if (|drop) overflow_q <= 1'b1;
      end
    end
  end

  // NOTE: queue storage has no reset; pointers and counts alone decide which entries are live.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int s = 0; s < 2; s++) begin
        if (push_ok[s]) mem_q[s][wptr_q[s]] <= in_res[s];
      end
    end
  end

  assign bus.alu_stall    = (count_q[0] >= STALL_CNT);
  assign bus.lsb_stall    = (count_q[1] >= STALL_CNT);
  assign bus.cdb_active   = cdb_active_q;
  assign bus.cdb_tag      = cdb_q.tag;
  assign bus.cdb_val      = cdb_q.val;
  assign bus.cdb_addr     = cdb_q.addr;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, ordering under contention, stalls,
// overflow, flush and rdy_in freeze, each with hand-derived expectations.
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic flush  = 1'b0;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.DEPTH(4), .NONE_TAG(4'd0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // ALU results carry 0xA in the top nibble, LSB results 0x5, so the source is visible on the bus.
  function automatic logic [31:0] alu_v(input logic [3:0] t);
    return 32'hA000_0000 | 32'(t);
  endfunction
  function automatic logic [31:0] lsb_v(input logic [3:0] t);
    return 32'h5000_0000 | 32'(t);
  endfunction
  function automatic logic [31:0] alu_a(input logic [3:0] t);
    return 32'hAAD0_0000 | 32'(t);
  endfunction
  function automatic logic [31:0] lsb_a(input logic [3:0] t);
    return 32'h5AD0_0000 | 32'(t);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_tag = 4'd0; bus.alu_val = '0; bus.alu_addr = '0;
    bus.lsb_valid = 1'b0; bus.lsb_tag = 4'd0; bus.lsb_val = '0; bus.lsb_addr = '0;
  endtask

  task automatic drive_alu(input logic [3:0] t);
    bus.alu_valid = 1'b1; bus.alu_tag = t; bus.alu_val = alu_v(t); bus.alu_addr = alu_a(t);
  endtask

  task automatic drive_lsb(input logic [3:0] t);
    bus.lsb_valid = 1'b1; bus.lsb_tag = t; bus.lsb_val = lsb_v(t); bus.lsb_addr = lsb_a(t);
  endtask

  task automatic apply_reset();
    drive_idle();
    flush  = 1'b0;
    rdy_in = 1'b1;
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    logic [71:0] outs;
    apply_reset();
    outs = {bus.cdb_active, bus.alu_stall, bus.lsb_stall, bus.overflow_err,
            bus.cdb_tag, bus.cdb_val, bus.cdb_addr};
    checks++;
    if (outs !== 72'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    // Both sources push for 6 edges: queues reach ALU=3, LSB=4.
    for (int i = 0; i < 6; i++) begin
      drive_alu(4'(1 + i));
      drive_lsb(4'(9 + i));
      tick();
    end
    checks++;
    if ({bus.alu_stall, bus.lsb_stall, bus.cdb_active} !== 3'b111) begin
      errors++; $display("FAIL reset_prestate: stalls/active=%b expected 111",
                         {bus.alu_stall, bus.lsb_stall, bus.cdb_active});
    end
    #2;
    rst_in = 1'b0;
    #1;
    outs = {bus.cdb_active, bus.alu_stall, bus.lsb_stall, bus.overflow_err,
            bus.cdb_tag, bus.cdb_val, bus.cdb_addr};
    checks++;
    if (outs !== 72'd0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", outs);
    end
    drive_idle();
    tick();
    tick();
    rst_in = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_val = 32'h11; bus.alu_addr = 32'h0;
    tick();
    drive_idle();
    checks++;
    if (bus.cdb_active !== 1'b0) begin
      errors++; $display("FAIL reset_first_push_early: cdb_active=%b expected 0", bus.cdb_active);
    end
    tick();
    checks++;
    if ({bus.cdb_active, bus.cdb_tag, bus.cdb_val} !== {1'b1, 4'd1, 32'h11}) begin
      errors++; $display("FAIL reset_first_push: active=%b tag=%0d val=%h expected 1/1/00000011",
                         bus.cdb_active, bus.cdb_tag, bus.cdb_val);
    end
    tick();
    checks++;
    if (bus.cdb_active !== 1'b0) begin
      errors++; $display("FAIL reset_single_broadcast: cdb_active=%b expected 0", bus.cdb_active);
    end
  endtask

  task automatic test_contention();
    int exp_act [6] = '{0, 1, 1, 1, 1, 0};
    int exp_tag [6] = '{0, 1, 5, 2, 6, 0};
    int exp_src [6] = '{0, 0, 1, 0, 1, 0};
    logic [31:0] ev, ea;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      if (i == 0) begin drive_alu(4'd1); drive_lsb(4'd5); end
      if (i == 1) begin drive_alu(4'd2); drive_lsb(4'd6); end
      tick();
      checks++;
      if (bus.cdb_active !== 1'(exp_act[i])) begin
        errors++; $display("FAIL contention_active[%0d]: got %b expected %0d", i, bus.cdb_active, exp_act[i]);
      end else if (exp_act[i] == 1) begin
        ev = (exp_src[i] == 1) ? lsb_v(4'(exp_tag[i])) : alu_v(4'(exp_tag[i]));
        ea = (exp_src[i] == 1) ? lsb_a(4'(exp_tag[i])) : alu_a(4'(exp_tag[i]));
        checks++;
        if ({bus.cdb_tag, bus.cdb_val, bus.cdb_addr} !== {4'(exp_tag[i]), ev, ea}) begin
          errors++; $display("FAIL contention_data[%0d]: tag=%0d val=%h addr=%h expected %0d/%h/%h",
                             i, bus.cdb_tag, bus.cdb_val, bus.cdb_addr, exp_tag[i], ev, ea);
        end
      end
    end
  endtask

  task automatic test_none_tag();
    apply_reset();
    bus.alu_valid = 1'b1; bus.alu_tag = 4'd0; bus.alu_val = 32'hDEAD_0000;
    bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd0; bus.lsb_val = 32'hDEAD_0001;
    tick();
    drive_idle();
    drive_alu(4'd3);
    tick();
    drive_idle();
    checks++;
    if (bus.cdb_active !== 1'b0) begin
      errors++; $display("FAIL none_tag_ignored: cdb_active=%b tag=%0d expected inactive",
                         bus.cdb_active, bus.cdb_tag);
    end
    tick();
    checks++;
    if ({bus.cdb_active, bus.cdb_tag} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL none_tag_next: active=%b tag=%0d expected 1/3", bus.cdb_active, bus.cdb_tag);
    end
    tick();
    checks++;
    if (bus.cdb_active !== 1'b0) begin
      errors++; $display("FAIL none_tag_drain: cdb_active=%b expected 0", bus.cdb_active);
    end
  endtask

  task automatic test_backpressure();
    // Both sources push 5 results; each queue only drains every other cycle.
    int exp_tag [12] = '{0, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 0};
    int exp_as  [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int exp_ls  [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive_idle();
      if (i < 5) begin drive_alu(4'(1 + i)); drive_lsb(4'(9 + i)); end
      tick();
      checks++;
      if ({bus.alu_stall, bus.lsb_stall} !== {1'(exp_as[i]), 1'(exp_ls[i])}) begin
        errors++; $display("FAIL backpressure_stall[%0d]: alu/lsb=%b%b expected %0d%0d",
                           i, bus.alu_stall, bus.lsb_stall, exp_as[i], exp_ls[i]);
      end
      checks++;
      if (exp_tag[i] == 0) begin
        if (bus.cdb_active !== 1'b0) begin
          errors++; $display("FAIL backpressure_cdb[%0d]: active=%b expected 0", i, bus.cdb_active);
        end
      end else if ({bus.cdb_active, bus.cdb_tag} !== {1'b1, 4'(exp_tag[i])}) begin
        errors++; $display("FAIL backpressure_cdb[%0d]: active=%b tag=%0d expected 1/%0d",
                           i, bus.cdb_active, bus.cdb_tag, exp_tag[i]);
      end
    end
    checks++;
    if (bus.overflow_err !== 1'b0) begin
      errors++; $display("FAIL backpressure_no_overflow: overflow_err=%b expected 0", bus.overflow_err);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] alu_seen [$];
    logic [3:0] lsb_seen [$];
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      drive_idle();
      if (i < 8) begin drive_alu(4'(1 + i)); drive_lsb(4'(8 + i)); end
      tick();
      if (bus.cdb_active === 1'b1) begin
        if (bus.cdb_val[31:28] == 4'hA) alu_seen.push_back(bus.cdb_tag);
        else                            lsb_seen.push_back(bus.cdb_tag);
      end
      // Edge 6 is a push and pop on a full LSB queue; edge 7 pushes into a full queue with no pop.
      if (i == 6) begin
        checks++;
        if (bus.overflow_err !== 1'b0) begin
          errors++; $display("FAIL overflow_push_pop_full: overflow_err=%b expected 0", bus.overflow_err);
        end
      end
      if (i == 7) begin
        checks++;
        if (bus.overflow_err !== 1'b1) begin
          errors++; $display("FAIL overflow_set: overflow_err=%b expected 1", bus.overflow_err);
        end
      end
    end
    checks++;
    if ({bus.overflow_err, bus.cdb_active} !== 2'b10) begin
      errors++; $display("FAIL overflow_sticky: overflow_err/active=%b expected 10",
                         {bus.overflow_err, bus.cdb_active});
    end
    checks++;
    if (alu_seen.size() != 8 || lsb_seen.size() != 7) begin
      errors++; $display("FAIL overflow_counts: alu=%0d lsb=%0d expected 8 and 7",
                         alu_seen.size(), lsb_seen.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (alu_seen[k] !== 4'(1 + k)) begin
          errors++; $display("FAIL overflow_alu_order[%0d]: got %0d expected %0d", k, alu_seen[k], 1 + k);
        end
      end
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (lsb_seen[k] !== 4'(8 + k)) begin
          errors++; $display("FAIL overflow_lsb_order[%0d]: got %0d expected %0d", k, lsb_seen[k], 8 + k);
        end
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    drive_alu(4'd1); drive_lsb(4'd5);
    tick();
    drive_alu(4'd2); drive_lsb(4'd6);
    tick();
    checks++;
    if ({bus.cdb_active, bus.cdb_tag} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL flush_before: active=%b tag=%0d expected 1/1", bus.cdb_active, bus.cdb_tag);
    end
    // Three results queued (ALU 2, LSB 5, LSB 6); the flush-cycle pushes must be lost too.
    flush = 1'b1;
    drive_alu(4'd3); drive_lsb(4'd7);
    tick();
    flush = 1'b0;
    drive_idle();
    checks++;
    if ({bus.cdb_active, bus.cdb_tag, bus.cdb_val} !== {1'b0, 4'd1, alu_v(4'd1)}) begin
      errors++; $display("FAIL flush_edge: active=%b tag=%0d val=%h expected 0/1/%h",
                         bus.cdb_active, bus.cdb_tag, bus.cdb_val, alu_v(4'd1));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.cdb_active, bus.alu_stall, bus.lsb_stall} !== 3'b000) begin
        errors++; $display("FAIL flush_quiet[%0d]: active/stalls=%b tag=%0d expected 000",
                           i, {bus.cdb_active, bus.alu_stall, bus.lsb_stall}, bus.cdb_tag);
      end
    end
    // After a flush the ALU wins the first tie again.
    drive_alu(4'd4); drive_lsb(4'd8);
    tick();
    drive_idle();
    tick();
    checks++;
    if ({bus.cdb_active, bus.cdb_tag} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL flush_regrant_alu: active=%b tag=%0d expected 1/4", bus.cdb_active, bus.cdb_tag);
    end
    tick();
    checks++;
    if ({bus.cdb_active, bus.cdb_tag} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL flush_regrant_lsb: active=%b tag=%0d expected 1/8", bus.cdb_active, bus.cdb_tag);
    end
    tick();
    checks++;
    if (bus.cdb_active !== 1'b0) begin
      errors++; $display("FAIL flush_regrant_end: active=%b tag=%0d expected 0", bus.cdb_active, bus.cdb_tag);
    end
  endtask

  task automatic test_rdy_freeze();
    int exp_tag [5] = '{5, 2, 6, 0, 0};
    apply_reset();
    drive_alu(4'd1); drive_lsb(4'd5);
    tick();
    drive_alu(4'd2); drive_lsb(4'd6);
    tick();
    // Frozen: pushes offered now must never appear.
    rdy_in = 1'b0;
    drive_alu(4'd9); drive_lsb(4'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.cdb_active, bus.cdb_tag, bus.cdb_val} !== {1'b1, 4'd1, alu_v(4'd1)}) begin
        errors++; $display("FAIL rdy_frozen[%0d]: active=%b tag=%0d val=%h expected 1/1/%h",
                           i, bus.cdb_active, bus.cdb_tag, bus.cdb_val, alu_v(4'd1));
      end
    end
    rdy_in = 1'b1;
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (exp_tag[i] == 0) begin
        if (bus.cdb_active !== 1'b0) begin
          errors++; $display("FAIL rdy_resume[%0d]: active=%b tag=%0d expected 0", i, bus.cdb_active, bus.cdb_tag);
        end
      end else if ({bus.cdb_active, bus.cdb_tag} !== {1'b1, 4'(exp_tag[i])}) begin
        errors++; $display("FAIL rdy_resume[%0d]: active=%b tag=%0d expected 1/%0d",
                           i, bus.cdb_active, bus.cdb_tag, exp_tag[i]);
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_contention();
    test_none_tag();
    test_backpressure();
    test_overflow();
    test_flush();
    test_rdy_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
